// File: rtl/srl_pkg.sv
// Shared definitions for the SRL-based FIFO: depth limit, tap address type
// and the occupancy counter width helper.
package srl_pkg;

    localparam int unsigned SRL_MAX_DEPTH = 128;

    // Wide enough to address any chain up to SRL_MAX_DEPTH entries.
    typedef logic [$clog2(SRL_MAX_DEPTH)-1:0] srl_addr_t;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned srl_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_chain.sv
// Addressable shift-register chain. No reset and no initial value so the
// storage maps onto SRL primitives. Entry 0 is the newest word.
module srl_chain
    import srl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    input  srl_addr_t        addr,
    output logic [WIDTH-1:0] q
);

    // Entry k occupies bits [k*WIDTH +: WIDTH].
    logic [DEPTH*WIDTH-1:0] sr_q;

    // Shift the whole chain by one entry on each enabled clock.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            sr_q <= {sr_q[(DEPTH-1)*WIDTH-1:0], d};
        end
    end

    // Combinational read tap; out-of-range addresses return zero.
    always_comb begin
        q = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (addr == srl_addr_t'(k)) begin
                q = sr_q[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Small-footprint first-word-fall-through FIFO. The controller owns the
// occupancy counter, handshakes, flags and sticky overflow bit; storage
// lives in an unreset SRL chain read at tap = level-1.
module srl_fifo_ctrl
    import srl_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned AFULL = DEPTH - 2,
    localparam int unsigned CNT_W = srl_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] level,
    output logic             almost_full,
    output logic             overflow_err
);

    if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH) begin : g_bad_depth
        $error("srl_fifo_ctrl: DEPTH out of range");
    end

    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_L = CNT_W'(AFULL);

    logic [CNT_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    srl_addr_t        tap;

    // Ready depends only on registered level, never on out_ready.
    assign in_ready     = (level_q != DEPTH_L);
    assign out_valid    = (level_q != '0);
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign level        = level_q;
    assign almost_full  = (level_q >= AFULL_L);
    assign overflow_err = overflow_q;

    // Oldest entry sits at level-1; wraps to an unused address when empty.
    assign tap = srl_addr_t'(level_q - CNT_W'(1));

    srl_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chain (
        .clk      (clk),
        .shift_en (push),
        .d        (in_data),
        .addr     (tap),
        .q        (out_data)
    );

    // Next occupancy and sticky overflow; flush wins over both.
    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - CNT_W'(1);
        end
        if (in_valid && !in_ready && !flush) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl at WIDTH=8, DEPTH=16, AFULL=14.
module tb_srl_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] level;
    logic             almost_full;
    logic             overflow_err;

    int checks = 0;
    int errors = 0;

    srl_fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AFULL (DEPTH - 2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #12;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_push3();
        logic [7:0] vec [3];
        vec = '{8'hA5, 8'h3C, 8'h0F};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vec[i];
            tick();
            checks++; if (level !== CNT_W'(i + 1)) begin errors++; $display("FAIL push3_level got %0d exp %0d", level, i + 1); end
            checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL push3_head got %h exp a5", out_data); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push3_valid got %b exp 1", out_valid); end
            checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL push3_afull got %b exp 0", almost_full); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        logic [7:0] vec [3];
        vec = '{8'hA5, 8'h3C, 8'h0F};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== vec[i]) begin errors++; $display("FAIL drain_data got %h exp %h", out_data, vec[i]); end
            tick();
            checks++; if (level !== CNT_W'(2 - i)) begin errors++; $display("FAIL drain_level got %0d exp %0d", level, 2 - i); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
            checks++; if (level !== CNT_W'(i + 1)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, i + 1); end
            checks++; if (almost_full !== ((i + 1) >= 14)) begin errors++; $display("FAIL fill_afull at %0d got %b", i + 1, almost_full); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_data = 8'hFF;
        tick();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow_err); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL overflow_level got %0d exp 16", level); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL overflow_head got %h exp 00", out_data); end
        // pop while full with in_valid high: no write-through
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_pop_level got %0d exp 15", level); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL fill_drain_data got %h exp %h", out_data, 8'(i)); end
            tick();
            checks++; if (level !== CNT_W'(15 - i)) begin errors++; $display("FAIL fill_drain_level got %0d exp %0d", level, 15 - i); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
        end
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL b2b_prefill got %0d exp 5", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h15 + 8'(i);
            checks++; if (out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_data got %h exp %h", out_data, 8'h10 + 8'(i)); end
            tick();
            checks++; if (level !== 5'd5) begin errors++; $display("FAIL b2b_level got %0d exp 5", level); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_data !== 8'h1A + 8'(i)) begin errors++; $display("FAIL b2b_tail got %h exp %h", out_data, 8'h1A + 8'(i)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i);
            tick();
        end
        checks++; if (level !== 5'd9) begin errors++; $display("FAIL flush_prefill got %0d exp 9", level); end
        flush = 1'b1; in_data = 8'h99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_push_level got %0d exp 1", level); end
        checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL flush_push_data got %h exp 77", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_pop_level got %0d exp 0", level); end
    endtask

    task automatic test_async_reset();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow_err); end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 5'd7) begin errors++; $display("FAIL areset_prefill got %0d exp 7", level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL areset_level got %0d exp 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL areset_overflow got %b exp 0", overflow_err); end
        #3;
        rst_n = 1'b1;
        tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL areset_after got %0d exp 0", level); end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_drain();
        test_fill_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
